// File: rtl/trap_entry_seq_pkg.sv
// Shared types and constants for the trap-entry sequencer: state encoding,
// trap codes, the code->tt table, register-file slots and reset vectors.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    WR_PC,
    WR_NPC,
    VECTOR,
    DONE,
    ERROR
  } state_t;

  localparam logic [2:0] TT_CODE_NONE     = 3'd0;
  localparam logic [2:0] TT_CODE_RESET    = 3'd1;
  localparam logic [2:0] TT_CODE_IACC     = 3'd2;
  localparam logic [2:0] TT_CODE_ILLEGAL  = 3'd3;
  localparam logic [2:0] TT_CODE_PRIV     = 3'd4;
  localparam logic [2:0] TT_CODE_WOVF     = 3'd5;
  localparam logic [2:0] TT_CODE_WUNF     = 3'd6;
  localparam logic [2:0] TT_CODE_TICC     = 3'd7;

  localparam logic [7:0] TT_RESET         = 8'h00;
  localparam logic [7:0] TT_IACC          = 8'h01;
  localparam logic [7:0] TT_ILLEGAL       = 8'h02;
  localparam logic [7:0] TT_PRIV          = 8'h03;
  localparam logic [7:0] TT_WOVF          = 8'h05;
  localparam logic [7:0] TT_WUNF          = 8'h06;
  localparam logic [7:0] TT_TICC          = 8'h80;

  localparam logic [4:0]  RF_ADDR_PC      = 5'd17;
  localparam logic [4:0]  RF_ADDR_NPC     = 5'd18;

  localparam logic [31:0] RESET_PC        = 32'h0000_0000;
  localparam logic [31:0] RESET_NPC       = 32'h0000_0004;

  typedef struct packed {
    logic        busy;
    logic        ack;
    logic        psr_we;
    logic        et_clr;
    logic        s_set;
    logic        ps_val;
    logic        cwp_dec;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        pc_load;
    logic [31:0] pc_next;
    logic [31:0] npc_next;
    logic        error_mode;
  } seq_out_t;

  function automatic logic [7:0] tt_of_code(input logic [2:0] code);
    case (code)
      TT_CODE_RESET:   return TT_RESET;
      TT_CODE_IACC:    return TT_IACC;
      TT_CODE_ILLEGAL: return TT_ILLEGAL;
      TT_CODE_PRIV:    return TT_PRIV;
      TT_CODE_WOVF:    return TT_WOVF;
      TT_CODE_WUNF:    return TT_WUNF;
      TT_CODE_TICC:    return TT_TICC;
      default:         return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/trap_entry_seq_if.sv
// Bundle between the trap encoder / datapath (master) and the trap-entry
// sequencer (slave).
interface trap_entry_seq_if #(
  parameter int unsigned TBA_W = 20
);
  logic [2:0]       tt_code;
  logic             tt_valid;
  logic             et;
  logic             s;
  logic [TBA_W-1:0] tba;
  logic [31:0]      pc;
  logic [31:0]      npc;

  logic             busy;
  logic             ack;
  logic [7:0]       tt_out;
  logic             psr_we;
  logic             et_clr;
  logic             s_set;
  logic             ps_val;
  logic             cwp_dec;
  logic             rf_we;
  logic [4:0]       rf_addr;
  logic [31:0]      rf_data;
  logic             pc_load;
  logic [31:0]      pc_next;
  logic [31:0]      npc_next;
  logic             error_mode;

  modport master (
    output tt_code, tt_valid, et, s, tba, pc, npc,
    input  busy, ack, tt_out, psr_we, et_clr, s_set, ps_val, cwp_dec,
           rf_we, rf_addr, rf_data, pc_load, pc_next, npc_next, error_mode
  );

  modport slave (
    input  tt_code, tt_valid, et, s, tba, pc, npc,
    output busy, ack, tt_out, psr_we, et_clr, s_set, ps_val, cwp_dec,
           rf_we, rf_addr, rf_data, pc_load, pc_next, npc_next, error_mode
  );
endinterface

// File: rtl/trap_entry_seq_decode.sv
// Combinational decode of the encoder's 3-bit trap code into the SPARC tt
// field, plus a flag for the reset code.
module tt_code_decode
  import trap_pkg::*;
(
  input  logic [2:0] code,
  output logic [7:0] tt,
  output logic       is_reset
);

  assign tt       = tt_of_code(code);
  assign is_reset = (code == TT_CODE_RESET);

endmodule

// File: rtl/trap_entry_seq.sv
// Trap-entry sequencer: captures a trap code and walks PSR update, PC/nPC save
// and vectoring. Define TRAP_ENTRY_ERRMODE_EN to enable the ET=0 error state.
module trap_entry_seq
  import trap_pkg::*;
#(
  parameter int unsigned TBA_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  trap_entry_seq_if.slave  bus
);

  state_t           state, state_d;
  seq_out_t         outs, outs_d;

  logic [7:0]       dec_tt;
  logic             dec_rst;
  logic             capture;

  logic             cap_s, cap_rst;
  logic [31:0]      cap_pc, cap_npc;
  logic [TBA_W-1:0] cap_tba;
  logic [7:0]       tt_q;

  logic             s_d, rst_d;
  logic [31:0]      pc_d, npc_d, vec_pc;
  logic [TBA_W-1:0] tba_d;
  logic [7:0]       tt_d;

  tt_code_decode u_decode (
    .code     (bus.tt_code),
    .tt       (dec_tt),
    .is_reset (dec_rst)
  );

  assign capture = (state == IDLE) && bus.tt_valid && (bus.tt_code != TT_CODE_NONE);

  // Strobes are registered from the next state, so the values they carry must
  // come from the inputs on the capture edge and from the captures afterwards.
  assign s_d   = capture ? bus.s   : cap_s;
  assign rst_d = capture ? dec_rst : cap_rst;
  assign pc_d  = capture ? bus.pc  : cap_pc;
  assign npc_d = capture ? bus.npc : cap_npc;
  assign tba_d = capture ? bus.tba : cap_tba;
  assign tt_d  = capture ? dec_tt  : tt_q;

`ifndef TRAP_ENTRY_ERRMODE_EN
  logic unused_et;
  assign unused_et = bus.et;
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (capture) begin
          if (dec_rst)      state_d = VECTOR;
`ifdef TRAP_ENTRY_ERRMODE_EN
          else if (!bus.et) state_d = ERROR;
`endif
          else              state_d = SAVE;
        end
      end
      SAVE:   state_d = WR_PC;
      WR_PC:  state_d = WR_NPC;
      WR_NPC: state_d = VECTOR;
      VECTOR: state_d = DONE;
      DONE:   state_d = IDLE;
`ifdef TRAP_ENTRY_ERRMODE_EN
      ERROR:  state_d = ERROR;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outs_d      = '0;
    vec_pc      = {tba_d, tt_d, 4'b0000};
    outs_d.busy = (state_d != IDLE);
    case (state_d)
      SAVE: begin
        outs_d.psr_we  = 1'b1;
        outs_d.et_clr  = 1'b1;
        outs_d.s_set   = 1'b1;
        outs_d.ps_val  = s_d;
        outs_d.cwp_dec = 1'b1;
      end
      WR_PC: begin
        outs_d.rf_we   = 1'b1;
        outs_d.rf_addr = RF_ADDR_PC;
        outs_d.rf_data = pc_d;
      end
      WR_NPC: begin
        outs_d.rf_we   = 1'b1;
        outs_d.rf_addr = RF_ADDR_NPC;
        outs_d.rf_data = npc_d;
      end
      VECTOR: begin
        outs_d.pc_load = 1'b1;
        if (rst_d) begin
          outs_d.pc_next  = RESET_PC;
          outs_d.npc_next = RESET_NPC;
          outs_d.psr_we   = 1'b1;
          outs_d.et_clr   = 1'b1;
          outs_d.s_set    = 1'b1;
          outs_d.ps_val   = s_d;
        end else begin
          outs_d.pc_next  = vec_pc;
          outs_d.npc_next = vec_pc + 32'd4;
        end
      end
      DONE: outs_d.ack = 1'b1;
`ifdef TRAP_ENTRY_ERRMODE_EN
      ERROR: outs_d.error_mode = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      outs    <= '0;
      tt_q    <= '0;
      cap_s   <= 1'b0;
      cap_rst <= 1'b0;
      cap_pc  <= '0;
      cap_npc <= '0;
      cap_tba <= '0;
    end else begin
      state <= state_d;
      outs  <= outs_d;
      if (capture) begin
        tt_q    <= dec_tt;
        cap_s   <= bus.s;
        cap_rst <= dec_rst;
        cap_pc  <= bus.pc;
        cap_npc <= bus.npc;
        cap_tba <= bus.tba;
      end
    end
  end

  assign bus.busy       = outs.busy;
  assign bus.ack        = outs.ack;
  assign bus.tt_out     = tt_q;
  assign bus.psr_we     = outs.psr_we;
  assign bus.et_clr     = outs.et_clr;
  assign bus.s_set      = outs.s_set;
  assign bus.ps_val     = outs.ps_val;
  assign bus.cwp_dec    = outs.cwp_dec;
  assign bus.rf_we      = outs.rf_we;
  assign bus.rf_addr    = outs.rf_addr;
  assign bus.rf_data    = outs.rf_data;
  assign bus.pc_load    = outs.pc_load;
  assign bus.pc_next    = outs.pc_next;
  assign bus.npc_next   = outs.npc_next;
  assign bus.error_mode = outs.error_mode;

endmodule

// File: tb/tb_trap_entry_seq.sv
// Directed bench for trap_entry_seq; strobe vector order is
// {busy, ack, psr_we, et_clr, s_set, ps_val, cwp_dec, rf_we, pc_load, error_mode}.
module tb_trap_entry_seq;

  localparam logic [9:0] ST_IDLE     = 10'h000;
  localparam logic [9:0] ST_SAVE_S0  = 10'h2E8;
  localparam logic [9:0] ST_SAVE_S1  = 10'h2F8;
  localparam logic [9:0] ST_RFWR     = 10'h204;
  localparam logic [9:0] ST_VEC      = 10'h202;
  localparam logic [9:0] ST_RVEC_S0  = 10'h2E2;
  localparam logic [9:0] ST_DONE     = 10'h300;
  localparam logic [9:0] ST_ERR      = 10'h201;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  trap_entry_seq_if #(.TBA_W(20)) ifc ();

  trap_entry_seq #(.TBA_W(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] strobes();
    return {ifc.busy, ifc.ack, ifc.psr_we, ifc.et_clr, ifc.s_set,
            ifc.ps_val, ifc.cwp_dec, ifc.rf_we, ifc.pc_load, ifc.error_mode};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    ifc.tt_code  = 3'd0;
    ifc.tt_valid = 1'b0;
    ifc.et       = 1'b1;
    ifc.s        = 1'b0;
    ifc.tba      = 20'h00040;
    ifc.pc       = 32'h0000_0100;
    ifc.npc      = 32'h0000_0104;
    step();
    step();
    chk("reset_strobes", {22'd0, strobes()}, {22'd0, ST_IDLE});
    chk("reset_tt_out",  {24'd0, ifc.tt_out}, 32'h0);
    chk("reset_pc_next", ifc.pc_next, 32'h0);
    reset = 1'b0;
    step();

    // Normal trap, illegal_instr
    ifc.tt_code = 3'd3; ifc.tt_valid = 1'b1;
    step();
    ifc.tt_valid = 1'b0; ifc.tt_code = 3'd0;
    ifc.pc = 32'hDEAD_BEEF; ifc.npc = 32'hCAFE_F00D; ifc.tba = 20'hFFFFF; ifc.s = 1'b1;
    chk("a_save",   {22'd0, strobes()}, {22'd0, ST_SAVE_S0});
    chk("a_tt_out", {24'd0, ifc.tt_out}, 32'h02);
    step();
    chk("a_wrpc",      {22'd0, strobes()}, {22'd0, ST_RFWR});
    chk("a_wrpc_addr", {27'd0, ifc.rf_addr}, 32'd17);
    chk("a_wrpc_data", ifc.rf_data, 32'h0000_0100);
    step();
    chk("a_wrnpc",      {22'd0, strobes()}, {22'd0, ST_RFWR});
    chk("a_wrnpc_addr", {27'd0, ifc.rf_addr}, 32'd18);
    chk("a_wrnpc_data", ifc.rf_data, 32'h0000_0104);
    step();
    chk("a_vec",     {22'd0, strobes()}, {22'd0, ST_VEC});
    chk("a_pc_next", ifc.pc_next,  32'h0004_0020);
    chk("a_npc_next", ifc.npc_next, 32'h0004_0024);
    step();
    chk("a_done", {22'd0, strobes()}, {22'd0, ST_DONE});
    step();
    chk("a_idle", {22'd0, strobes()}, {22'd0, ST_IDLE});
    chk("a_tt_hold", {24'd0, ifc.tt_out}, 32'h02);

    // Reset code with ET=0
    ifc.s = 1'b0; ifc.et = 1'b0; ifc.pc = 32'h55; ifc.npc = 32'h59;
    ifc.tt_code = 3'd1; ifc.tt_valid = 1'b1;
    step();
    ifc.tt_valid = 1'b0; ifc.tt_code = 3'd0;
    chk("b_vec",      {22'd0, strobes()}, {22'd0, ST_RVEC_S0});
    chk("b_pc_next",  ifc.pc_next,  32'h0);
    chk("b_npc_next", ifc.npc_next, 32'h4);
    chk("b_tt_out",   {24'd0, ifc.tt_out}, 32'h00);
    step();
    chk("b_done", {22'd0, strobes()}, {22'd0, ST_DONE});
    step();
    chk("b_idle", {22'd0, strobes()}, {22'd0, ST_IDLE});

    // Window overflow with ET=0
    ifc.tba = 20'h12345; ifc.s = 1'b1;
    ifc.tt_code = 3'd5; ifc.tt_valid = 1'b1;
    step();
    ifc.tt_valid = 1'b0; ifc.tt_code = 3'd0;
    chk("c_tt_out", {24'd0, ifc.tt_out}, 32'h05);
`ifdef TRAP_ENTRY_ERRMODE_EN
    chk("c_err", {22'd0, strobes()}, {22'd0, ST_ERR});
    ifc.tt_code = 3'd3; ifc.tt_valid = 1'b1;
    step(); step(); step();
    ifc.tt_valid = 1'b0; ifc.tt_code = 3'd0;
    chk("c_err_sticky", {22'd0, strobes()}, {22'd0, ST_ERR});
    #2 reset = 1'b1;
    #1;
    chk("c_err_reset", {22'd0, strobes()}, {22'd0, ST_IDLE});
    step();
    reset = 1'b0;
`else
    chk("c_save", {22'd0, strobes()}, {22'd0, ST_SAVE_S1});
    step(); step(); step();
    chk("c_vec",      {22'd0, strobes()}, {22'd0, ST_VEC});
    chk("c_pc_next",  ifc.pc_next,  32'h1234_5050);
    chk("c_npc_next", ifc.npc_next, 32'h1234_5054);
    step(); step();
    chk("c_idle", {22'd0, strobes()}, {22'd0, ST_IDLE});
`endif
    step();

    // trap_instr, second strobe while busy is dropped
    ifc.et = 1'b1; ifc.s = 1'b0; ifc.tba = 20'h00040;
    ifc.tt_code = 3'd7; ifc.tt_valid = 1'b1;
    step();
    ifc.tt_valid = 1'b0; ifc.tt_code = 3'd0;
    chk("d_tt_out", {24'd0, ifc.tt_out}, 32'h80);
    step();
    ifc.tt_code = 3'd2; ifc.tt_valid = 1'b1;
    step();
    ifc.tt_valid = 1'b0; ifc.tt_code = 3'd0;
    chk("d_wrnpc", {22'd0, strobes()}, {22'd0, ST_RFWR});
    step();
    chk("d_pc_next", ifc.pc_next, 32'h0004_0800);
    step();
    chk("d_done", {22'd0, strobes()}, {22'd0, ST_DONE});
    step();
    chk("d_idle1", {22'd0, strobes()}, {22'd0, ST_IDLE});
    step();
    chk("d_idle2", {22'd0, strobes()}, {22'd0, ST_IDLE});
    chk("d_tt_hold", {24'd0, ifc.tt_out}, 32'h80);

    // Async reset mid-trap, then a clean privileged_instr trap
    ifc.tt_code = 3'd4; ifc.tt_valid = 1'b1;
    step();
    ifc.tt_valid = 1'b0; ifc.tt_code = 3'd0;
    step(); step();
    chk("e_pre_reset", {22'd0, strobes()}, {22'd0, ST_RFWR});
    #2 reset = 1'b1;
    #1;
    chk("e_reset_strobes", {22'd0, strobes()}, {22'd0, ST_IDLE});
    chk("e_reset_tt",      {24'd0, ifc.tt_out}, 32'h0);
    chk("e_reset_rf_data", ifc.rf_data, 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("e_idle_after", {22'd0, strobes()}, {22'd0, ST_IDLE});
    ifc.pc = 32'h0000_2000; ifc.npc = 32'h0000_2004;
    ifc.tt_code = 3'd4; ifc.tt_valid = 1'b1;
    step();
    ifc.tt_valid = 1'b0; ifc.tt_code = 3'd0;
    chk("e_save",   {22'd0, strobes()}, {22'd0, ST_SAVE_S0});
    chk("e_tt_out", {24'd0, ifc.tt_out}, 32'h03);
    step();
    chk("e_wrpc_data", ifc.rf_data, 32'h0000_2000);
    step();
    chk("e_wrnpc_data", ifc.rf_data, 32'h0000_2004);
    step();
    chk("e_pc_next",  ifc.pc_next,  32'h0004_0030);
    chk("e_npc_next", ifc.npc_next, 32'h0004_0034);
    step();
    chk("e_done", {22'd0, strobes()}, {22'd0, ST_DONE});
    step();

    // Strobe with code 0 is ignored
    ifc.tt_code = 3'd0; ifc.tt_valid = 1'b1;
    step();
    chk("f_idle1", {22'd0, strobes()}, {22'd0, ST_IDLE});
    step();
    ifc.tt_valid = 1'b0;
    chk("f_idle2", {22'd0, strobes()}, {22'd0, ST_IDLE});
    chk("f_tt_hold", {24'd0, ifc.tt_out}, 32'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
